// File: rtl/uart_byte_bridge.sv
// UART (8N1, LSB first) bridge between a host serial line and the port block's load/datain and enout/dataout/ready streams.
// Define UART_PARITY_EN for 8E1 framing (even parity bit on both RX and TX).
module uart_byte_bridge #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic       load,
    output logic [7:0] datain,
    output logic       ready,
    input  logic       enout,
    input  logic [7:0] dataout,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
`ifdef UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP,
        T_HOLD
    } tx_state_t;

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_meta;
    logic            rxs;
`ifdef UART_PARITY_EN
    logic            rx_par_err;
`endif

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
`ifdef UART_PARITY_EN
    logic            tx_par;
`endif

    // Synchroniser flops reset to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            datain    <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            load <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rxs)
                        rx_state <= R_START;
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rxs ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= R_PARITY;
`else
                            rx_state <= R_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                R_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_err <= rxs ^ (^rx_shift);
                        rx_state   <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rxs) begin
                            rx_state <= R_IDLE;
`ifdef UART_PARITY_EN
                            if (rx_par_err) begin
                                frame_err <= 1'b1;
                            end else begin
                                datain <= rx_shift;
                                load   <= 1'b1;
                            end
`else
                            datain <= rx_shift;
                            load   <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= R_BREAK;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (rxs)
                        rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // T_HOLD keeps a still-high enout from launching a second frame; ready rises as enout is seen low.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
            ready    <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                T_IDLE: begin
                    txd    <= 1'b1;
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (enout) begin
                        tx_shift <= dataout;
`ifdef UART_PARITY_EN
                        tx_par   <= ^dataout;
`endif
                        ready    <= 1'b0;
                        txd      <= 1'b0;
                        tx_state <= T_START;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                T_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= T_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd      <= tx_par;
                            tx_state <= T_PARITY;
`else
                            txd      <= 1'b1;
                            tx_state <= T_STOP;
`endif
                        end else begin
                            txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                T_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        txd      <= 1'b1;
                        tx_state <= T_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                T_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= T_HOLD;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                T_HOLD: begin
                    if (!enout) begin
                        ready    <= 1'b1;
                        tx_state <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Scoreboard bench for uart_byte_bridge at CLKS_PER_BIT=16: stimulus queues expected bytes, negedge monitors pop and compare.
module tb_uart_byte_bridge;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       txd;
    logic       load;
    logic [7:0] datain;
    logic       ready;
    logic       enout;
    logic [7:0] dataout;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int load_count = 0;
    int tx_frames = 0;
    bit tx_discard = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int load_cycles[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    uart_byte_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .txd(txd),
        .load(load),
        .datain(datain),
        .ready(ready),
        .enout(enout),
        .dataout(dataout),
        .frame_err(frame_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one serial frame on rxd; stop_ok=0 forces the stop bit low and leaves rxd low.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_ok;
        tick(CPB);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (load === 1'b1) begin
                load_count++;
                load_cycles.push_back(cycle);
                if (rx_q.size() == 0)
                    checkOutput("rx_unexpected_load", 32'd1, 32'd0);
                else
                    checkOutput("rx_datain", {24'd0, datain}, {24'd0, rx_q.pop_front()});
            end
        end
    end

    // Decodes each txd frame at mid-bit, starting from the first low cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd === 1'b0) begin : frame
                logic [7:0] b;
                logic start_bit;
                logic stop_bit;
                repeat (CPB / 2 - 1) @(negedge clk);
                start_bit = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = txd;
                if (tx_discard) begin
                    tx_discard = 1'b0;
                end else begin
                    tx_frames++;
                    checkOutput("tx_start_bit", {31'd0, start_bit}, 32'd0);
                    checkOutput("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
                    if (tx_q.size() == 0)
                        checkOutput("tx_unexpected_frame", 32'd1, 32'd0);
                    else
                        checkOutput("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int base;
        int start_cycle;
        int n;
        int edges;
        int frames0;
        bit low_ok;
        logic prev;

        reset = 1'b1;
        rxd = 1'b1;
        enout = 1'b0;
        dataout = 8'h00;
        tick(3);
        checkOutput("reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("reset_load", {31'd0, load}, 32'd0);
        checkOutput("reset_datain", {24'd0, datain}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("ready_after_reset", {31'd0, ready}, 32'd1);

        base = load_count;
        rx_q.push_back(8'hA5);
        start_cycle = cycle;
        applyStimulus(8'hA5, 1'b1);
        tick(20);
        checkOutput("rx_a5_load_count", load_count - base, 32'd1);
        checkOutput("rx_a5_frame_err", {31'd0, frame_err}, 32'd0);
        n = (load_cycles.size() > 0) ? load_cycles[$] - start_cycle : 0;
        checkOutput("rx_latency_ok", {31'd0, (n >= 153 && n <= 156)}, 32'd1);

        base = load_count;
        rx_q.push_back(8'h23);
        rx_q.push_back(8'h00);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'h00, 1'b1);
        tick(20);
        checkOutput("rx_b2b_load_count", load_count - base, 32'd2);
        n = (load_cycles.size() >= 2) ? load_cycles[$] - load_cycles[$-1] : 0;
        checkOutput("rx_b2b_gap_ok", {31'd0, (n >= 158 && n <= 162)}, 32'd1);
        checkOutput("rx_b2b_frame_err", {31'd0, frame_err}, 32'd0);

        base = load_count;
        applyStimulus(8'h5A, 1'b0);
        tick(100);
        rxd = 1'b1;
        tick(20);
        checkOutput("rx_break_no_load", load_count - base, 32'd0);
        checkOutput("rx_break_frame_err", {31'd0, frame_err}, 32'd1);
        rx_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        tick(20);
        checkOutput("rx_after_break_load", load_count - base, 32'd1);

        tx_q.push_back(8'h3C);
        dataout = 8'h3C;
        enout = 1'b1;
        tick(1);
        checkOutput("tx_accept_ready", {31'd0, ready}, 32'd0);
        checkOutput("tx_accept_txd", {31'd0, txd}, 32'd0);
        enout = 1'b0;
        dataout = 8'hFF;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput("tx_ready_return_ok", {31'd0, (n >= 161 && n <= 163)}, 32'd1);
        tick(20);

        frames0 = tx_frames;
        rx_q.push_back(8'hC3);
        tx_q.push_back(8'h96);
        dataout = 8'h96;
        enout = 1'b1;
        fork
            applyStimulus(8'hC3, 1'b1);
        join_none
        low_ok = 1'b1;
        tick(1);
        for (int i = 0; i < 299; i++) begin
            if (ready !== 1'b0)
                low_ok = 1'b0;
            tick(1);
        end
        checkOutput("tx_hold_ready_low", {31'd0, low_ok}, 32'd1);
        enout = 1'b0;
        tick(1);
        checkOutput("tx_hold_ready_rise", {31'd0, ready}, 32'd1);
        tick(20);
        checkOutput("tx_hold_one_frame", tx_frames - frames0, 32'd1);

        tx_discard = 1'b1;
        dataout = 8'h0F;
        enout = 1'b1;
        tick(1);
        enout = 1'b0;
        tick(49);
        reset = 1'b1;
        tick(1);
        checkOutput("reset_mid_tx_txd", {31'd0, txd}, 32'd1);
        reset = 1'b0;
        tick(1);
        checkOutput("reset_mid_tx_ready", {31'd0, ready}, 32'd1);
        edges = 0;
        prev = txd;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (txd !== prev)
                edges++;
            prev = txd;
        end
        checkOutput("reset_mid_tx_no_edges", edges, 32'd0);

        checkOutput("rx_queue_drained", rx_q.size(), 32'd0);
        checkOutput("tx_queue_drained", tx_q.size(), 32'd0);
        checkOutput("total_loads", load_count, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
